// File: rtl/par16_transmitter_pkg.sv
// Shared encodings and constants for the 16-bit parallel bus transmitter.
// The sync words are shared with par16_receiver.
package par16_transmitter_pkg;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_LOW  = 2'd1,
        TX_WAIT_HIGH = 2'd2
    } tx_state_e;

    typedef enum logic {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pk_state_e;

    localparam logic [7:0]  PAD_BYTE_DEFAULT = 8'h00;
    localparam logic [15:0] SYNC_WORD_A      = 16'hB8B8;
    localparam logic [15:0] SYNC_WORD_B      = 16'h8B8B;

endpackage

// File: rtl/par16_word_fifo.sv
// Synchronous word FIFO with extra-MSB pointers for full/empty detection.
// A pop while full frees the slot for a push in the same cycle.
module par16_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/par16_transmitter.sv
// FPGA-to-master transmitter: packs bytes MSB-first into words, buffers them,
// and hands one word per master bus_clk cycle while the master reads.
module par16_transmitter
    import par16_transmitter_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  txd_data,
    input  logic        txd_valid,
    output logic        txd_ready,
    input  logic        flush,
    input  logic        bus_clk,
    input  logic        bus_rnw,
    output logic [15:0] bus_data,
    output logic        bus_oe,
    output logic        busy,
    output logic [15:0] tx_count
);
    logic        r_clk_meta, r_clk_s, r_rnw_meta, r_rnw_s;
    logic        r_rdy_en;
    pk_state_e   r_pk_state;
    logic [7:0]  r_hi;
    tx_state_e   r_tx_state, w_tx_next;
    logic        r_held;
    logic [15:0] r_word, r_bus_data, r_tx_count;
    logic        w_full, w_empty, w_accept, w_push, w_pop, w_load, w_done;
    logic [15:0] w_push_data, w_fifo_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b0;
            r_clk_s    <= 1'b0;
            r_rnw_meta <= 1'b0;
            r_rnw_s    <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_clk_meta <= bus_clk;
            r_clk_s    <= r_clk_meta;
            r_rnw_meta <= bus_rnw;
            r_rnw_s    <= r_rnw_meta;
            r_rdy_en   <= 1'b1;
        end
    end

    // r_rdy_en keeps txd_ready low while reset is held, despite an empty FIFO
    assign txd_ready = r_rdy_en && !w_full;
    assign w_accept  = txd_valid && txd_ready;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = {r_hi, txd_data};
        if (r_pk_state == PK_HALF) begin
            if (w_accept) begin
                w_push = 1'b1;
            end else if (flush && !w_full) begin
                w_push      = 1'b1;
                w_push_data = {r_hi, PAD_BYTE};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pk_state <= PK_EMPTY;
            r_hi       <= 8'h00;
        end else if (w_accept) begin
            if (r_pk_state == PK_EMPTY) begin
                r_hi       <= txd_data;
                r_pk_state <= PK_HALF;
            end else begin
                r_pk_state <= PK_EMPTY;
            end
        end else if (r_pk_state == PK_HALF && flush && !w_full) begin
            r_pk_state <= PK_EMPTY;
        end
    end

    par16_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A held word survives the master aborting a read and is resent later
    always_comb begin
        w_tx_next = r_tx_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (r_rnw_s && (r_held || !w_empty)) begin
                w_pop     = !r_held;
                w_tx_next = TX_WAIT_LOW;
            end
            TX_WAIT_LOW: begin
                if (!r_rnw_s) begin
                    w_tx_next = TX_IDLE;
                end else if (!r_clk_s) begin
                    w_load    = 1'b1;
                    w_tx_next = TX_WAIT_HIGH;
                end
            end
            TX_WAIT_HIGH: if (r_clk_s) begin
                w_done    = 1'b1;
                w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_held     <= 1'b0;
            r_word     <= 16'h0000;
            r_bus_data <= 16'h0000;
            r_tx_count <= 16'h0000;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_pop) begin
                r_word <= w_fifo_dout;
                r_held <= 1'b1;
            end
            if (w_load) r_bus_data <= r_word;
            if (w_done) begin
                r_held     <= 1'b0;
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

    assign bus_data = r_bus_data;
    assign bus_oe   = r_rnw_s;
    assign tx_count = r_tx_count;
    assign busy     = (r_tx_state != TX_IDLE) || r_held || !w_empty ||
                      (r_pk_state == PK_HALF);

endmodule

// File: tb/tb_par16_transmitter.sv
// Directed bench for par16_transmitter: packing, flush, backpressure,
// aborted reads and asynchronous reset.
module tb_par16_transmitter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  txd_data = 8'h00;
    logic        txd_valid = 1'b0;
    logic        txd_ready;
    logic        flush = 1'b0;
    logic        bus_clk = 1'b0;
    logic        bus_rnw = 1'b0;
    logic [15:0] bus_data;
    logic        bus_oe;
    logic        busy;
    logic [15:0] tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    par16_transmitter dut (
        .clk       (clk),
        .reset     (reset),
        .txd_data  (txd_data),
        .txd_valid (txd_valid),
        .txd_ready (txd_ready),
        .flush     (flush),
        .bus_clk   (bus_clk),
        .bus_rnw   (bus_rnw),
        .bus_data  (bus_data),
        .bus_oe    (bus_oe),
        .busy      (busy),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; bus_rnw = 1'b0; bus_clk = 1'b0;
        txd_valid = 1'b0; flush = 1'b0; txd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        txd_data = b; txd_valid = 1'b1;
        @(negedge clk);
        while (!txd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1 txd_valid = 1'b0;
    endtask

    task automatic read_word(output logic [15:0] w);
        bus_clk = 1'b0; bus_rnw = 1'b1;
        repeat (8) @(posedge clk);
        #1 w = bus_data;
        bus_clk = 1'b1;
        repeat (8) @(posedge clk);
        #1 bus_clk = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus_data !== 16'h0000) begin n_fail++; $display("FAIL rst_bus_data: got %h want 0000", bus_data); end
        n_checks++; if (bus_oe !== 1'b0) begin n_fail++; $display("FAIL rst_bus_oe: got %b want 0", bus_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL rst_tx_count: got %h want 0000", tx_count); end
        n_checks++; if (txd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_txd_ready: got %b want 0", txd_ready); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (txd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", txd_ready); end
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        do_reset();
        send_byte(8'h12);
        send_byte(8'h34);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_pending: got %b want 1", busy); end
        read_word(w);
        n_checks++; if (w !== 16'h1234) begin n_fail++; $display("FAIL single_data: got %h want 1234", w); end
        n_checks++; if (bus_oe !== 1'b1) begin n_fail++; $display("FAIL single_bus_oe: got %b want 1", bus_oe); end
        bus_rnw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", tx_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_checks++; if (bus_oe !== 1'b0) begin n_fail++; $display("FAIL single_bus_oe_low: got %b want 0", bus_oe); end
    endtask

    task automatic test_flush();
        logic [15:0] w;
        do_reset();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_empty_noop: busy %b want 0", busy); end
        send_byte(8'hAB);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_half_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        read_word(w);
        n_checks++; if (w !== 16'hAB00) begin n_fail++; $display("FAIL flush_data: got %h want ab00", w); end
        bus_rnw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", tx_count); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        logic [15:0] exp_w [5];
        int n = 0;
        exp_w[0] = 16'h0102; exp_w[1] = 16'h0304; exp_w[2] = 16'h0506;
        exp_w[3] = 16'h0708; exp_w[4] = 16'h090A;
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        n_checks++; if (txd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", txd_ready); end
        txd_data = 8'h09; txd_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (txd_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b want 0", txd_ready); end
        bus_rnw = 1'b1;
        @(negedge clk);
        while (!txd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n >= 50) begin n_fail++; $display("FAIL full_release: ready stayed %b want 1", txd_ready); end
        @(posedge clk);
        #1 txd_valid = 1'b0;
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) begin
            read_word(w);
            n_checks++; if (w !== exp_w[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, w, exp_w[i]); end
        end
        bus_rnw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", tx_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort_read();
        logic [15:0] w;
        do_reset();
        send_byte(8'hCA);
        send_byte(8'hFE);
        bus_clk = 1'b1; bus_rnw = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (bus_data !== 16'h0000) begin n_fail++; $display("FAIL abort_not_loaded: got %h want 0000", bus_data); end
        bus_rnw = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL abort_count0: got %0d want 0", tx_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_held_busy: got %b want 1", busy); end
        read_word(w);
        n_checks++; if (w !== 16'hCAFE) begin n_fail++; $display("FAIL abort_resend: got %h want cafe", w); end
        read_word(w);
        n_checks++; if (w !== 16'hCAFE) begin n_fail++; $display("FAIL abort_stale: got %h want cafe", w); end
        bus_rnw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL abort_count1: got %0d want 1", tx_count); end
    endtask

    task automatic test_flush_collide();
        logic [15:0] w;
        do_reset();
        send_byte(8'h55);
        flush = 1'b1;
        send_byte(8'h56);
        flush = 1'b0;
        read_word(w);
        n_checks++; if (w !== 16'h5556) begin n_fail++; $display("FAIL collide_data: got %h want 5556", w); end
        read_word(w);
        bus_rnw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL collide_count: got %0d want 1", tx_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL collide_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        do_reset();
        for (int i = 1; i <= 6; i++) send_byte(8'hA0 + 8'(i));
        read_word(w);
        n_checks++; if (w !== 16'hA1A2) begin n_fail++; $display("FAIL mid_first: got %h want a1a2", w); end
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (bus_data !== 16'hA3A4) begin n_fail++; $display("FAIL mid_second: got %h want a3a4", bus_data); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if (bus_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0000", bus_data); end
        n_checks++; if (bus_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_oe: got %b want 0", bus_oe); end
        n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", tx_count); end
        n_checks++; if (txd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", txd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (txd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", txd_ready); end
        read_word(w);
        read_word(w);
        n_checks++; if (w !== 16'h0000) begin n_fail++; $display("FAIL mid_empty_data: got %h want 0000", w); end
        n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL mid_empty_count: got %0d want 0", tx_count); end
        bus_rnw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_flush();
        test_backpressure();
        test_abort_read();
        test_flush_collide();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
